// File: rtl/pulse_pacer.sv
// Source-domain pulse pacer: counts incoming event strobes and re-emits them
// one per GAP cycles so each pulse survives a crossing into a slower clock.
module pulse_pacer #(
    parameter int GAP   = 4,
    parameter int CNT_W = 3
) (
    input  logic             clksrc,
    input  logic             rstb_clksrc,
    input  logic             pulse_in,
    input  logic             ovf_clr,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             ovf
);

    localparam int               GC_W    = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GC_W-1:0]  GC_LOAD = GC_W'(GAP - 2);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GAP  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pending_nxt;
    logic [GC_W-1:0]  r_gap_cnt;
    logic [GC_W-1:0]  w_gap_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_drop;

    // Saturating increment: a full counter holds its value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        if (inc && (v != CNT_MAX)) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_gap_cnt_nxt = r_gap_cnt;
        w_pulse_nxt   = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // An arriving event and an emit cancel out, so the count never overflows here.
                if ((r_pending != '0) || pulse_in) begin
                    w_pulse_nxt   = 1'b1;
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = GC_LOAD;
                    if (!pulse_in) begin
                        w_pending_nxt = r_pending - 1'b1;
                    end
                end
            end
            S_GAP: begin
                w_pending_nxt = sat_inc(r_pending, pulse_in);
                w_drop        = pulse_in && (r_pending == CNT_MAX);
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        if (w_drop) begin
            w_ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf;
        end
    end

    always_ff @(posedge clksrc or negedge rstb_clksrc) begin
        if (!rstb_clksrc) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_gap_cnt <= '0;
            r_pulse   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_pulse   <= w_pulse_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign pulse_out = r_pulse;
    assign pending   = r_pending;
    assign busy      = (r_pending != '0) || (r_state == S_GAP);
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pulse_pacer.sv
// Bench for pulse_pacer: directed scenarios plus random traffic, checked
// against an event-count / last-emit-time model of the pacing rules.
module tb_pulse_pacer;

    localparam int GAP   = 4;
    localparam int CNT_W = 3;
    localparam int MAXP  = (1 << CNT_W) - 1;

    logic             clksrc      = 1'b0;
    logic             rstb_clksrc = 1'b0;
    logic             pulse_in    = 1'b0;
    logic             ovf_clr     = 1'b0;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;
    logic [CNT_W+2:0] w_obs;

    pulse_pacer #(.GAP(GAP), .CNT_W(CNT_W)) dut (
        .clksrc      (clksrc),
        .rstb_clksrc (rstb_clksrc),
        .pulse_in    (pulse_in),
        .ovf_clr     (ovf_clr),
        .pulse_out   (pulse_out),
        .pending     (pending),
        .busy        (busy),
        .ovf         (ovf)
    );

    assign w_obs = {pulse_out, pending, busy, ovf};

    always #5 clksrc = ~clksrc;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending count, time of the last emitted pulse, sticky flag.
    int m_pend;
    int m_last;
    int m_t;
    bit m_ovf;
    bit m_pulse;
    int m_events;
    int m_drops;
    int dut_pulses;

    task automatic model_reset();
        m_pend  = 0;
        m_last  = -1000;
        m_t     = 0;
        m_ovf   = 1'b0;
        m_pulse = 1'b0;
    endtask

    function automatic logic [CNT_W+2:0] m_vec();
        bit m_busy;
        m_busy = (m_pend != 0) || ((m_t - m_last) <= GAP - 2);
        return {m_pulse, CNT_W'(m_pend), m_busy, m_ovf};
    endfunction

    task automatic edge_step(input bit in, input bit clr);
        bit drop;
        pulse_in = in;
        ovf_clr  = clr;
        @(posedge clksrc);
        m_t++;
        drop = 1'b0;
        if (((m_t - m_last) >= GAP) && ((m_pend > 0) || in)) begin
            m_pend  = m_pend + int'(in) - 1;
            m_last  = m_t;
            m_pulse = 1'b1;
        end else begin
            m_pulse = 1'b0;
            if (in) begin
                if (m_pend == MAXP) begin
                    drop = 1'b1;
                    m_drops++;
                end else begin
                    m_pend++;
                end
            end
        end
        if (in) m_events++;
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        if (pulse_out) dut_pulses++;
    endtask

    task automatic test_reset();
        rstb_clksrc = 1'b0;
        pulse_in    = 1'b0;
        ovf_clr     = 1'b0;
        repeat (3) @(posedge clksrc);
        @(negedge clksrc);
        rstb_clksrc = 1'b1;
        model_reset();
        n_total++;
        if (w_obs !== '0) $display("FAIL reset_release: got %b exp %b", w_obs, {(CNT_W+3){1'b0}});
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            edge_step(1'b0, 1'b0);
            n_total++;
            if (w_obs !== '0) $display("FAIL reset_idle[%0d]: got %b exp %b", i, w_obs, {(CNT_W+3){1'b0}});
            else n_pass++;
        end
    endtask

    task automatic test_single_event();
        int pulses;
        pulses = 0;
        edge_step(1'b1, 1'b0);
        n_total++;
        if (pulse_out !== 1'b1 || pending !== '0) $display("FAIL single_latency: got pulse=%b pend=%0d exp pulse=1 pend=0", pulse_out, pending);
        else n_pass++;
        pulses = 1;
        for (int i = 0; i < 8; i++) begin
            edge_step(1'b0, 1'b0);
            if (pulse_out) pulses++;
            n_total++;
            if (w_obs !== m_vec()) $display("FAIL single_cycle[%0d]: got %b exp %b", i, w_obs, m_vec());
            else n_pass++;
        end
        n_total++;
        if (pulses != 1) $display("FAIL single_count: got %0d exp 1", pulses);
        else n_pass++;
    endtask

    task automatic test_burst();
        int exp_pend[13] = '{0, 1, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        bit exp_pls[13]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            edge_step(i < 3, 1'b0);
            n_total++;
            if (pulse_out !== exp_pls[i] || int'(pending) != exp_pend[i])
                $display("FAIL burst[%0d]: got pulse=%b pend=%0d exp pulse=%b pend=%0d",
                         i, pulse_out, pending, exp_pls[i], exp_pend[i]);
            else n_pass++;
            n_total++;
            if (w_obs !== m_vec()) $display("FAIL burst_model[%0d]: got %b exp %b", i, w_obs, m_vec());
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        int pulse_at[$];
        pulse_at.delete();
        for (int i = 0; i < 52; i++) begin
            edge_step(i < 12, 1'b0);
            if (pulse_out) pulse_at.push_back(i);
            n_total++;
            if (w_obs !== m_vec()) $display("FAIL ovf_model[%0d]: got %b exp %b", i, w_obs, m_vec());
            else n_pass++;
            if (i == 9) begin
                n_total++;
                if (int'(pending) != MAXP || ovf !== 1'b0) $display("FAIL ovf_fill: got pend=%0d ovf=%b exp pend=%0d ovf=0", pending, ovf, MAXP);
                else n_pass++;
            end
            if (i == 10) begin
                n_total++;
                if (ovf !== 1'b1 || int'(pending) != MAXP) $display("FAIL ovf_set: got ovf=%b pend=%0d exp ovf=1 pend=%0d", ovf, pending, MAXP);
                else n_pass++;
            end
        end
        n_total++;
        if (pulse_at.size() != 10) $display("FAIL ovf_count: got %0d exp 10", pulse_at.size());
        else n_pass++;
        for (int j = 1; j < pulse_at.size(); j++) begin
            n_total++;
            if (pulse_at[j] - pulse_at[j-1] != GAP) $display("FAIL ovf_spacing[%0d]: got %0d exp %0d", j, pulse_at[j] - pulse_at[j-1], GAP);
            else n_pass++;
        end
    endtask

    task automatic test_ovf_collision();
        for (int i = 0; i < 10; i++) edge_step(1'b1, 1'b0);
        edge_step(1'b1, 1'b1);
        n_total++;
        if (ovf !== 1'b1 || m_ovf !== 1'b1) $display("FAIL clr_vs_drop: got ovf=%b exp 1", ovf);
        else n_pass++;
        edge_step(1'b0, 1'b1);
        n_total++;
        if (ovf !== 1'b0) $display("FAIL clr_alone: got ovf=%b exp 0", ovf);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            edge_step(1'b0, 1'b0);
            n_total++;
            if (w_obs !== m_vec()) $display("FAIL clr_drain[%0d]: got %b exp %b", i, w_obs, m_vec());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        for (int i = 0; i < 7; i++) edge_step(1'b1, 1'b0);
        n_total++;
        if (int'(pending) != 5 || busy !== 1'b1 || w_obs !== m_vec()) $display("FAIL mid_setup: got pend=%0d busy=%b exp pend=5 busy=1", pending, busy);
        else n_pass++;
        pulse_in = 1'b0;
        #2;
        rstb_clksrc = 1'b0;
        #1;
        n_total++;
        if (w_obs !== '0) $display("FAIL mid_reset_async: got %b exp %b", w_obs, {(CNT_W+3){1'b0}});
        else n_pass++;
        rstb_clksrc = 1'b1;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            edge_step(1'b0, 1'b0);
            if (pulse_out) pulses++;
        end
        n_total++;
        if (pulses != 0 || w_obs !== '0) $display("FAIL mid_after_release: got pulses=%0d obs=%b exp pulses=0 obs=0", pulses, w_obs);
        else n_pass++;
    endtask

    task automatic test_random();
        bit in;
        bit clr;
        m_events   = 0;
        m_drops    = 0;
        dut_pulses = 0;
        for (int i = 0; i < 400; i++) begin
            in  = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            clr = ($urandom_range(0, 15) == 0);
            edge_step(in, clr);
            n_total++;
            if (w_obs !== m_vec()) $display("FAIL rand[%0d]: got %b exp %b", i, w_obs, m_vec());
            else n_pass++;
        end
        for (int i = 0; i < 40; i++) edge_step(1'b0, 1'b0);
        n_total++;
        if (dut_pulses != m_events - m_drops) $display("FAIL rand_conservation: got %0d pulses exp %0d", dut_pulses, m_events - m_drops);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || pending !== '0) $display("FAIL rand_drained: got busy=%b pend=%0d exp busy=0 pend=0", busy, pending);
        else n_pass++;
    endtask

    initial begin
        m_events   = 0;
        m_drops    = 0;
        dut_pulses = 0;
        model_reset();
        test_reset();
        test_single_event();
        test_burst();
        test_overflow();
        test_ovf_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
